// File: rtl/alu_shift_pkg.sv
// Shared opcodes, FSM states and width defaults for the multi-cycle shift unit.
// ALU_SHIFT_ROTATE_EN enables the rotate / rotate-through-carry opcodes.
package alu_shift_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 5;

  localparam logic [3:0] OP_SHL = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0001;
  localparam logic [3:0] OP_SAR = 4'b0010;
  localparam logic [3:0] OP_SAL = 4'b0011;
  localparam logic [3:0] OP_ROL = 4'b0100;
  localparam logic [3:0] OP_ROR = 4'b0101;
  localparam logic [3:0] OP_RCL = 4'b0110;
  localparam logic [3:0] OP_RCR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SHIFT_ROTATE_EN
    return (op[3] == 1'b0);
`else
    return (op[3:2] == 2'b00);
`endif
  endfunction

  function automatic logic op_through_carry(input logic [3:0] op);
    return (op == OP_RCL) || (op == OP_RCR);
  endfunction

  function automatic logic op_tracks_ov(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SAL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shift/rotate step: (op, w, c) -> (w_n, c_n, sign_changed).
// Rotate cases exist only when ALU_SHIFT_ROTATE_EN is defined.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] w,
  input  logic              c,
  output logic [DATA_W-1:0] w_n,
  output logic              c_n,
  output logic              sign_changed
);

  always_comb begin
    w_n = w;
    c_n = c;
    case (op)
      OP_SHL, OP_SAL: {c_n, w_n} = {w, 1'b0};
      OP_SHR:         {w_n, c_n} = {1'b0, w};
      OP_SAR:         {w_n, c_n} = {w[DATA_W-1], w};
`ifdef ALU_SHIFT_ROTATE_EN
      OP_ROL: begin
        w_n = {w[DATA_W-2:0], w[DATA_W-1]};
        c_n = w[DATA_W-1];
      end
      OP_ROR: begin
        w_n = {w[0], w[DATA_W-1:1]};
        c_n = w[0];
      end
      OP_RCL:         {c_n, w_n} = {w, c};
      OP_RCR:         {w_n, c_n} = {c, w};
`endif
      default: ;
    endcase
  end

  assign sign_changed = w[DATA_W-1] ^ w_n[DATA_W-1];

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate execution unit with start/done handshake, one bit per clock.
// Define ALU_SHIFT_ROTATE_EN to make ROL/ROR/RCL/RCR legal.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              carryout,
  output logic              overflow,
  output logic              zero,
  output logic              N,
  output logic              err
);

  state_t            state, state_n;
  logic [3:0]        op_r;
  logic [DATA_W-1:0] w_r, w_n;
  logic              c_r, c_n;
  logic              ov_r, ill_r, sc;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_in;
  logic              accept;
  logic              unused_in1;

  assign cnt_in     = in1[CNT_W-1:0];
  assign accept     = (state == IDLE) && start;
  assign unused_in1 = ^in1[DATA_W-1:CNT_W];

  alu_shift_step #(.DATA_W(DATA_W)) u_step (
    .op           (op_r),
    .w            (w_r),
    .c            (c_r),
    .w_n          (w_n),
    .c_n          (c_n),
    .sign_changed (sc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((cnt_in == '0) || !op_legal(op1)) state_n = FIN;
          else                                  state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(1)) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Carry starts as cin only for the through-carry ops; every other op overwrites it on
  // the first step, so this also yields carryout=0 for a zero count on non-RC ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= '0;
      w_r      <= '0;
      c_r      <= 1'b0;
      ov_r     <= 1'b0;
      ill_r    <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      N        <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= op1;
            w_r   <= in0;
            cnt_r <= cnt_in;
            c_r   <= op_legal(op1) && op_through_carry(op1) && cin;
            ov_r  <= 1'b0;
            ill_r <= !op_legal(op1);
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          w_r   <= w_n;
          c_r   <= c_n;
          cnt_r <= cnt_r - CNT_W'(1);
          if (op_tracks_ov(op_r)) ov_r <= ov_r | sc;
        end
        FIN: begin
          out  <= w_r;
          done <= 1'b1;
          busy <= 1'b0;
          err  <= ill_r;
          if (ill_r) begin
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            N        <= 1'b0;
          end else begin
            carryout <= c_r;
            overflow <= ov_r;
            zero     <= (w_r == '0);
            N        <= w_r[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed vectors, randomized ops against a
// bit-rotation reference model, back-to-back issue, ignored start and reset abort.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [3:0]  op1;
  logic [31:0] in0, in1;
  logic        busy, done, carryout, overflow, zero, N, err;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

`ifdef ALU_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] o;
    logic c, v, z, n, e;
  } res_t;

  alu_shift_seq #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .in0(in0), .in1(in1), .cin(cin),
    .busy(busy), .done(done), .out(dout), .carryout(carryout), .overflow(overflow),
    .zero(zero), .N(N), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input int n,
                                 input logic ci);
    res_t r;
    logic [32:0] v;
    logic [31:0] s, m;
    r = '0;
    r.o = a;
    if (!((op < 4) || (ROT && op < 8))) begin
      r.e = 1'b1;
      return r;
    end
    if (n == 0) begin
      r.c = (op == 4'd6 || op == 4'd7) ? ci : 1'b0;
    end else begin
      v = {ci, a};
      case (op)
        4'd0, 4'd3: begin
          r.o = a << n;
          r.c = a[32-n];
          s = a >> (31 - n);
          m = 32'((33'd1 << (n + 1)) - 33'd1);
          r.v = !(s == 32'd0 || s == m);
        end
        4'd1: begin r.o = a >> n; r.c = a[n-1]; end
        4'd2: begin r.o = $signed(a) >>> n; r.c = a[n-1]; end
        4'd4: begin r.o = (a << n) | (a >> (32 - n)); r.c = r.o[0]; end
        4'd5: begin r.o = (a >> n) | (a << (32 - n)); r.c = r.o[31]; end
        4'd6: begin v = (v << n) | (v >> (33 - n)); r.o = v[31:0]; r.c = v[32]; end
        default: begin v = (v >> n) | (v << (33 - n)); r.o = v[31:0]; r.c = v[32]; end
      endcase
    end
    r.z = (r.o == 32'd0);
    r.n = r.o[31];
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input int n);
    if (!((op < 4) || (ROT && op < 8))) return 1;
    return (n == 0) ? 1 : n + 1;
  endfunction

  // Issue one op; after acceptance the inputs are scrambled to expose re-sampling.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, output res_t got, output int lat, output logic bsy);
    @(negedge clk);
    op1 = op; in0 = a; in1 = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    bsy = busy;
    start = 1'b0;
    op1 = 4'($urandom); in0 = $urandom; in1 = $urandom; cin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done !== 1'b1 && lat < 40);
    got = '{dout, carryout, overflow, zero, N, err};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op1 = '0; in0 = '0; in1 = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dout, carryout, overflow, zero, N, err} !== 39'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b out=%h c=%b v=%b z=%b n=%b e=%b, want all 0",
               busy, done, dout, carryout, overflow, zero, N, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [7];
    logic [31:0] as  [7];
    logic [31:0] ns  [7];
    logic        cis [7];
    res_t        exps[7];
    int          lats[7];
    res_t got;
    int   lat;
    logic bsy;
    ops[0] = 4'd0;  as[0] = 32'h8000_0001; ns[0] = 1; cis[0] = 0;
    exps[0] = '{32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; lats[0] = 2;
    ops[1] = 4'd2;  as[1] = 32'hF000_0000; ns[1] = 4; cis[1] = 0;
    exps[1] = '{32'hFF00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; lats[1] = 5;
    ops[2] = 4'd7;  as[2] = 32'h0000_0001; ns[2] = 1; cis[2] = 1;
    exps[2] = ROT ? '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}
                  : '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lats[2] = ROT ? 2 : 1;
    ops[3] = 4'd1;  as[3] = 32'h1234_5678; ns[3] = 0; cis[3] = 1;
    exps[3] = '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; lats[3] = 1;
    ops[4] = 4'd1;  as[4] = 32'h0000_0001; ns[4] = 1; cis[4] = 0;
    exps[4] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; lats[4] = 2;
    ops[5] = 4'hF;  as[5] = 32'h0000_0000; ns[5] = 7; cis[5] = 1;
    exps[5] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; lats[5] = 1;
    ops[6] = 4'd6;  as[6] = 32'h0000_0005; ns[6] = 0; cis[6] = 1;
    exps[6] = ROT ? '{32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
                  : '{32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lats[6] = 1;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], ns[i], cis[i], got, lat, bsy);
      checks++;
      if (got !== exps[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h, want %h", i, got, exps[i]);
      end
      checks++;
      if (lat !== lats[i]) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, lats[i]);
      end
    end
  endtask

  task automatic test_random(input int iters);
    res_t got, exp;
    int   lat, n;
    logic bsy;
    logic [3:0]  op;
    logic [31:0] a;
    logic        ci;
    for (int i = 0; i < iters; i++) begin
      op = (i % 4 == 3) ? 4'($urandom) : 4'($urandom_range(0, 7));
      a  = $urandom;
      if (i % 5 == 0) a = {{8{a[31]}}, a[23:0]};
      n  = (i % 7 == 0) ? 0 : ((i % 7 == 1) ? 31 : int'($urandom_range(1, 31)));
      ci = 1'($urandom);
      exp = model(op, a, n, ci);
      do_op(op, a, {$urandom_range(0, 32'h07FF_FFFF), 5'(n)}, ci, got, lat, bsy);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] op=%h a=%h n=%0d ci=%b: got %h, want %h",
                 i, op, a, n, ci, got, exp);
      end
      checks++;
      if (lat !== model_lat(op, n) || bsy !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] timing: got lat=%0d busy=%b, want lat=%0d busy=1",
                 i, lat, bsy, model_lat(op, n));
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t got;
    int   lat;
    logic bsy;
    do_op(4'd0, 32'h0000_00FF, 32'd3, 1'b0, got, lat, bsy);
    do_op(4'd2, 32'h8000_0000, 32'd31, 1'b0, got, lat, bsy);
    checks++;
    if (bsy !== 1'b1 || lat !== 32 || got !== model(4'd2, 32'h8000_0000, 31, 1'b0)) begin
      errors++;
      $display("FAIL back_to_back: got busy=%b lat=%0d res=%h, want busy=1 lat=32 res=%h",
               bsy, lat, got, model(4'd2, 32'h8000_0000, 31, 1'b0));
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    @(negedge clk);
    op1 = 4'd1; in0 = 32'h0000_0001; in1 = 32'd1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    op1 = 4'd0; in0 = 32'hFFFF_FFFF; in1 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1 || dout !== 32'd0 || zero !== 1'b1 || carryout !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got dones=%0d out=%h z=%b c=%b, want dones=1 out=0 z=1 c=1",
               dones, dout, zero, carryout);
    end
  endtask

  task automatic test_abort();
    res_t got;
    int   lat;
    int   dones = 0;
    logic bsy;
    do_op(4'd0, 32'h0000_0001, 32'd3, 1'b0, got, lat, bsy);
    @(negedge clk);
    op1 = 4'd0; in0 = 32'h0000_0F0F; in1 = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, dout, carryout, overflow, zero, N, err} !== 39'd0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b out=%h c=%b v=%b z=%b n=%b e=%b, want all 0",
               busy, done, dout, carryout, overflow, zero, N, err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    end
    do_op(4'd3, 32'h4000_0003, 32'd2, 1'b0, got, lat, bsy);
    checks++;
    if (got !== model(4'd3, 32'h4000_0003, 2, 1'b0) || lat !== 3) begin
      errors++;
      $display("FAIL abort_restart: got res=%h lat=%0d, want res=%h lat=3",
               got, lat, model(4'd3, 32'h4000_0003, 2, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(80);
    test_back_to_back();
    test_ignore_start();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
